uart_msg_rx: RTL

//  Assembles bytes from the UART receiver into fixed-size {payload, header} messages and buffers them in a

---
 rtl/uart_msg_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_msg_rx.sv
// uart_msg_rx: assembles UART bytes into {payload, header} messages (header byte
// first, payload LSB first) and queues them in a first-word fall-through FIFO.
// Optional inter-byte gap timeout is compiled in with `define UART_RX_TIMEOUT_EN.
module uart_msg_rx #(
  parameter int HEADER_W       = 8,
  parameter int PAYLOAD_W      = 64,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          uart_in_avail,
  input  logic                          uart_in_req,
  output logic [HEADER_W+PAYLOAD_W-1:0] uart_in_msg,
  output logic                          uart_in_full,
  output logic                          msg_dropped,
  output logic                          msg_timeout
);

  localparam int MSG_W  = HEADER_W + PAYLOAD_W;
  localparam int NBYTES = MSG_W / 8;
  localparam int IW     = $clog2(NBYTES);
  localparam int AW     = $clog2(DEPTH);

  // Reject parameter sets the byte indexing and pointer wrap cannot handle.
  if ((MSG_W % 8) != 0 || NBYTES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_msg_rx: unsupported parameter combination");
  end

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [MSG_W-1:0]  asm_q, asm_d;
  logic              commit;
  logic              timeout_hit;

  logic [MSG_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic              full_q;
  logic              drop_q;
  logic              push;
  logic              pop;

`ifdef UART_RX_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0]     gap_q, gap_d;
  logic              to_q;

  // Timeout fires once the gap counter has reached the limit while a message is partial.
  always_comb begin
    timeout_hit = (state_q == S_COLLECT) && (gap_q == GW'(TIMEOUT_CYCLES));
  end

  // Gap counter: cleared by any byte or while idle, otherwise counts up and saturates.
  always_comb begin
    gap_d = gap_q;
    if (rx_valid || state_q == S_IDLE || timeout_hit) begin
      gap_d = '0;
    end else if (gap_q != GW'(TIMEOUT_CYCLES)) begin
      gap_d = gap_q + GW'(1);
    end
  end

  // Gap counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      gap_q <= '0;
      to_q  <= 1'b0;
    end else begin
      gap_q <= gap_d;
      to_q  <= timeout_hit;
    end
  end

  assign msg_timeout = to_q;
`else
  // Without the timeout a partial message waits indefinitely.
  always_comb begin
    timeout_hit = 1'b0;
  end

  assign msg_timeout = 1'b0;
`endif

  // Assembler next state: place each byte at its index, commit on the last one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    commit  = 1'b0;
    if (timeout_hit) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end
    if (rx_valid) begin
      if (state_q == S_IDLE || timeout_hit) begin
        asm_d      = '0;
        asm_d[7:0] = rx_data;
        idx_d      = IW'(1);
        state_d    = S_COLLECT;
      end else begin
        asm_d[8*idx_q +: 8] = rx_data;
        if (idx_q == IW'(NBYTES - 1)) begin
          commit  = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    end
  end

  // FIFO control: a commit is refused only when full and not popped in the same cycle.
  always_comb begin
    pop      = uart_in_req && (count_q != '0);
    push     = commit && ((count_q != (AW+1)'(DEPTH)) || pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    msg_d    = msg_q;
    if (count_d != '0) begin
      // The new head is the message being written this cycle when it lands in the head slot.
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        msg_d = asm_d;
      end else begin
        msg_d = mem[rd_ptr_d];
      end
    end
  end

  // Message storage: written on an accepted commit, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= asm_d;
    end
  end

  // State, pointers, occupancy and registered outputs.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      asm_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      msg_q    <= '0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      msg_q    <= msg_d;
      full_q   <= (count_d == (AW+1)'(DEPTH));
      drop_q   <= commit && !push;
    end
  end

  assign uart_in_avail = (count_q != '0);
  assign uart_in_msg   = msg_q;
  assign uart_in_full  = full_q;
  assign msg_dropped   = drop_q;

endmodule
